bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2; number of bus masters (2..8); index 0 is the CPU core, index 1 the DMA controller.
REQ-002 SHALL have parameter ADDR_W, default 16; word address width.
REQ-003 SHALL have parameter DATA_W, default 16; data width.
REQ-004 SHALL have parameter TIMEOUT, default 255; maximum wait-state cycles per access, where 0 disables the timeout.
REQ-005 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port m_req  in  N_MASTERS  per-master access request.
REQ-008 SHALL have port m_we  in  N_MASTERS  per-master write enable.
REQ-009 SHALL have port m_byte_en  in  N_MASTERS  per-master byte access.
REQ-010 SHALL have port m_byte_sel  in  N_MASTERS  per-master byte lane select.
REQ-011 SHALL have port m_addr  in  N_MASTERS*ADDR_W  packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port m_wdata  in  N_MASTERS*DATA_W  packed write data.
REQ-013 SHALL have port m_gnt  out  N_MASTERS  one-hot grant.
REQ-014 SHALL have port m_done  out  N_MASTERS  one-cycle completion pulse.
REQ-015 SHALL have port m_err  out  N_MASTERS  one-cycle timeout pulse.
REQ-016 SHALL have port m_rdata  out  DATA_W  read data, shared by all masters.
REQ-017 SHALL have ports s_en, s_we, s_byte_en, s_byte_sel  out  1 each  slave strobes.
REQ-018 SHALL have ports s_addr  out  ADDR_W and s_wdata  out  DATA_W.
REQ-019 SHALL have ports s_wait  in  1 (the OR of the mem and mmio waits) and s_rdata  in  DATA_W.

Function
REQ-020 SHALL implement the FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-021 IDLE: when any m_req is high, SHALL pick a winner, register its one-hot m_gnt, latch its we/byte/addr/wdata, and go to BUSY on the next edge.
REQ-022 BUSY: SHALL drive s_en=1 and the slave strobes from the latched copy; master inputs changing in BUSY SHALL have no effect.
REQ-023 BUSY with s_wait=0 at an edge: SHALL capture s_rdata into m_rdata, go to RESP, and clear the wait counter.
REQ-024 BUSY with s_wait=1: SHALL increment the wait counter; when TIMEOUT!=0 and the counter equals TIMEOUT, SHALL go to RESP with the error flag set and leave m_rdata unchanged.
REQ-025 RESP: SHALL pulse m_done[winner], or m_err[winner] on timeout (never both), for exactly one cycle, deassert m_gnt and s_en, and return to IDLE.
REQ-026 Minimum latency SHALL be req at edge 0, gnt/s_en at edge 1, done at edge 2 (zero wait states), so one access occupies 3 cycles.
REQ-027 A master dropping m_req in BUSY SHALL NOT abort the access; it completes normally.
REQ-028 m_rdata SHALL hold its value until the next successful read or write.
REQ-029 Simultaneous requests SHALL be resolved by the priority policy in REQ-033/034; exactly one grant is issued.
REQ-030 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits and SHALL saturate; it never wraps.

Reset
REQ-031 While rst_n=0 at an edge: FSM to IDLE; m_gnt, m_done, m_err, s_en, s_we, s_byte_en = 0; m_rdata, s_addr, s_wdata = 0; wait counter = 0; RR pointer = N_MASTERS-1 (so master 0 wins first).
REQ-032 Reset asserted mid-access SHALL abandon the access without a done/err pulse.

Configuration
REQ-033 With macro BUS_ARB_ROUND_ROBIN_EN defined: priority SHALL start at (last winner + 1) mod N_MASTERS, and the pointer SHALL update on every RESP.
REQ-034 Without BUS_ARB_ROUND_ROBIN_EN: fixed priority SHALL apply, lowest index wins (core over DMA), and no pointer register SHALL exist.

Structure
REQ-035 Package d16_bus_pkg SHALL hold the FSM state encoding (IDLE/BUSY/RESP) and the master index constants MASTER_CORE=0 and MASTER_DMA=1.
REQ-036 Sub-module arb_picker SHALL be combinational; it takes req and pointer and returns a one-hot winner, and is instantiated once.

Verification
REQ-037 Single read, master 0, addr 0x0123, s_wait=0, s_rdata=0xBEEF -> m_gnt=01 at cycle 1, m_done[0] at cycle 2, m_rdata=0xBEEF.
REQ-038 m_req=11 held for 4 accesses -> RR build grants 0,1,0,1; fixed build grants 0,0,0,0.
REQ-039 Write, master 1, s_wait high for 5 cycles -> s_en high for 6 cycles, s_addr/s_wdata stable throughout, a single m_done[1] pulse.
REQ-040 TIMEOUT=4 with s_wait stuck at 1 -> m_err pulses at cycle 6, no m_done, FSM returns to IDLE, m_rdata unchanged.
REQ-041 rst_n=0 during BUSY -> next cycle all outputs zero and no done/err pulse; a new request after reset is granted normally.
REQ-042 Master 0 changes m_addr and drops m_req during BUSY -> s_addr keeps the latched value and m_done[0] still pulses.

Source files
------------

// File: rtl/d16_bus_pkg.sv
// Shared definitions for the 16-bit bus arbiter: FSM encoding and master indices.
package d16_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } bus_state_t;

   localparam int MASTER_CORE = 0;
   localparam int MASTER_DMA  = 1;

endpackage

// File: rtl/bus_arbiter_arb_picker.sv
// Combinational winner selection: first requester found scanning upward from ptr+1 (wrapping).
module arb_picker #(
   parameter int N_MASTERS = 2,
   parameter int PTR_W     = $clog2(N_MASTERS)
) (
   input  logic [N_MASTERS-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   output logic [N_MASTERS-1:0] gnt
);

   always_comb begin
      int  idx;
      logic found;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         idx = (int'(ptr) + k) % N_MASTERS;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Single-slave bus arbiter, IDLE -> BUSY -> RESP per access.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise lowest index wins.
//
// state | meaning
// IDLE  | waiting for any request; winner picked and latched on the edge
// BUSY  | slave strobes driven from the latched copy, counting wait states
// RESP  | one-cycle done/err pulse to the winner, then back to IDLE
module bus_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS-1:0]          m_we,
   input  logic [N_MASTERS-1:0]          m_byte_en,
   input  logic [N_MASTERS-1:0]          m_byte_sel,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   output logic [N_MASTERS-1:0]          m_gnt,
   output logic [N_MASTERS-1:0]          m_done,
   output logic [N_MASTERS-1:0]          m_err,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          s_en,
   output logic                          s_we,
   output logic                          s_byte_en,
   output logic                          s_byte_sel,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   input  logic                          s_wait,
   input  logic [DATA_W-1:0]             s_rdata
);
   import d16_bus_pkg::*;

   localparam int PTR_W = $clog2(N_MASTERS);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

   bus_state_t           state_q, state_d;
   logic [N_MASTERS-1:0] gnt_q, win;
   logic                 err_q, we_q, be_q, bs_q;
   logic [ADDR_W-1:0]    addr_q, sel_addr;
   logic [DATA_W-1:0]    wdata_q, sel_wdata, rdata_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [PTR_W-1:0]     ptr_sel;
   logic                 sel_we, sel_be, sel_bs, timeout_hit;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic [PTR_W-1:0] ptr_q, gnt_idx;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_MASTERS; i++)
         if (gnt_q[i]) gnt_idx = PTR_W'(i);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                  ptr_q <= PTR_W'(N_MASTERS - 1);
      else if (state_q == ST_RESP) ptr_q <= gnt_idx;
   end

   assign ptr_sel = ptr_q;
`else
   // Pointer pinned to the top index so the scan always starts at master 0.
   assign ptr_sel = PTR_W'(N_MASTERS - 1);
`endif

   arb_picker #(.N_MASTERS(N_MASTERS), .PTR_W(PTR_W)) u_picker (
      .req (m_req),
      .ptr (ptr_sel),
      .gnt (win)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_be    = 1'b0;
      sel_bs    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (win[i]) begin
            sel_we    = m_we[i];
            sel_be    = m_byte_en[i];
            sel_bs    = m_byte_sel[i];
            sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = m_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_VAL);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (|m_req)                 state_d = ST_BUSY;
         ST_BUSY: if (!s_wait || timeout_hit) state_d = ST_RESP;
         ST_RESP:                             state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_q   <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 1'b0;
         bs_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|m_req) begin
                  gnt_q   <= win;
                  we_q    <= sel_we;
                  be_q    <= sel_be;
                  bs_q    <= sel_bs;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ST_BUSY: begin
               if (!s_wait) begin
                  rdata_q <= s_rdata;
                  cnt_q   <= '0;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
                  cnt_q <= '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // gnt_q is kept through RESP so the pulse reaches the right master.
   assign m_gnt      = (state_q == ST_BUSY) ? gnt_q : '0;
   assign m_done     = (state_q == ST_RESP && !err_q) ? gnt_q : '0;
   assign m_err      = (state_q == ST_RESP &&  err_q) ? gnt_q : '0;
   assign m_rdata    = rdata_q;
   assign s_en       = (state_q == ST_BUSY);
   assign s_we       = s_en & we_q;
   assign s_byte_en  = s_en & be_q;
   assign s_byte_sel = s_en & bs_q;
   assign s_addr     = addr_q;
   assign s_wdata    = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table of zero-wait accesses plus multi-cycle sequences.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  m_req, m_we, m_byte_en, m_byte_sel;
   logic [31:0] m_addr, m_wdata;
   logic        s_wait;
   logic [15:0] s_rdata;

   logic [1:0]  m_gnt, m_done, m_err;
   logic [15:0] m_rdata, s_addr, s_wdata;
   logic        s_en, s_we, s_byte_en, s_byte_sel;

   logic [1:0]  to_gnt, to_done, to_err;
   logic [15:0] to_rdata, to_s_addr, to_s_wdata;
   logic        to_s_en, to_s_we, to_s_byte_en, to_s_byte_sel;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_arbiter dut (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_byte_en(m_byte_en),
      .m_byte_sel(m_byte_sel), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt),
      .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata), .s_en(s_en), .s_we(s_we),
      .s_byte_en(s_byte_en), .s_byte_sel(s_byte_sel), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wait(s_wait), .s_rdata(s_rdata)
   );

   bus_arbiter #(.TIMEOUT(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_byte_en(m_byte_en),
      .m_byte_sel(m_byte_sel), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(to_gnt),
      .m_done(to_done), .m_err(to_err), .m_rdata(to_rdata), .s_en(to_s_en), .s_we(to_s_we),
      .s_byte_en(to_s_byte_en), .s_byte_sel(to_s_byte_sel), .s_addr(to_s_addr),
      .s_wdata(to_s_wdata), .s_wait(s_wait), .s_rdata(s_rdata)
   );

   typedef struct {
      logic [1:0]  req, we, be, bs;
      logic [15:0] a0, a1, w0, w1, rd;
      logic [1:0]  exp_gnt;
      logic        exp_we, exp_be, exp_bs;
      logic [15:0] exp_addr, exp_wdata;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      m_req = '0; m_we = '0; m_byte_en = '0; m_byte_sel = '0;
      m_addr = '0; m_wdata = '0; s_wait = 1'b0; s_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Caller sits at a negedge with both DUTs idle; returns at a negedge, idle again.
   task automatic run_vec(input vec_t v, input string tag);
      m_req = v.req; m_we = v.we; m_byte_en = v.be; m_byte_sel = v.bs;
      m_addr = {v.a1, v.a0}; m_wdata = {v.w1, v.w0}; s_wait = 1'b0; s_rdata = v.rd;
      @(negedge clk);
      chk({tag, " gnt"},      32'(m_gnt), 32'(v.exp_gnt));
      chk({tag, " s_en"},     32'(s_en), 32'd1);
      chk({tag, " s_we"},     32'(s_we), 32'(v.exp_we));
      chk({tag, " s_byte_en"},  32'(s_byte_en), 32'(v.exp_be));
      chk({tag, " s_byte_sel"}, 32'(s_byte_sel), 32'(v.exp_bs));
      chk({tag, " s_addr"},   32'(s_addr), 32'(v.exp_addr));
      chk({tag, " s_wdata"},  32'(s_wdata), 32'(v.exp_wdata));
      chk({tag, " done_early"}, 32'(m_done), 32'd0);
      m_req = '0;
      @(negedge clk);
      chk({tag, " done"},     32'(m_done), 32'(v.exp_gnt));
      chk({tag, " err"},      32'(m_err), 32'd0);
      chk({tag, " gnt_resp"}, 32'(m_gnt), 32'd0);
      chk({tag, " rdata"},    32'(m_rdata), 32'(v.rd));
      @(negedge clk);
      chk({tag, " done_once"}, 32'(m_done), 32'd0);
   endtask

   initial begin
      logic [1:0] exp_seq[4];
      logic [1:0] g;
      bit         seen;
      int         cnt_en, cnt_done, cnt_err, err_cyc, addr_bad, pulses;
      logic [1:0] err_val, done_val;
      vec_t       pre;

      vecs[0] = '{2'b01, 2'b00, 2'b00, 2'b00, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF,
                  2'b01, 1'b0, 1'b0, 1'b0, 16'h0123, 16'h0000};
      vecs[1] = '{2'b10, 2'b10, 2'b10, 2'b00, 16'h0AAA, 16'h4000, 16'h1111, 16'h1234, 16'h5555,
                  2'b10, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h1234};
      vecs[2] = '{2'b01, 2'b01, 2'b01, 2'b01, 16'h0FFF, 16'h0F0F, 16'h00AB, 16'h9999, 16'h0000,
                  2'b01, 1'b1, 1'b1, 1'b1, 16'h0FFF, 16'h00AB};
      vecs[3] = '{2'b10, 2'b01, 2'b01, 2'b10, 16'h1111, 16'hFFFF, 16'h2222, 16'h3333, 16'hA5A5,
                  2'b10, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h3333};
      vecs[4] = '{2'b01, 2'b10, 2'b10, 2'b11, 16'h8001, 16'h7FFE, 16'hFFFF, 16'h0000, 16'h0F0F,
                  2'b01, 1'b0, 1'b0, 1'b1, 16'h8001, 16'hFFFF};

      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      chk("rst gnt",    32'(m_gnt), 32'd0);
      chk("rst done",   32'(m_done | m_err), 32'd0);
      chk("rst s_en",   32'({s_en, s_we, s_byte_en}), 32'd0);
      chk("rst rdata",  32'(m_rdata), 32'd0);
      chk("rst s_addr", 32'({s_addr, s_wdata}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Both masters requesting continuously for four accesses.
`ifdef BUS_ARB_ROUND_ROBIN_EN
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      do_reset();
      m_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         g = '0;
         for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (m_gnt != 0) begin
               seen = 1'b1;
               g = m_gnt;
            end
         end
         chk($sformatf("prio seen%0d", k), 32'(seen), 32'd1);
         chk($sformatf("prio gnt%0d", k), 32'(g), 32'(exp_seq[k]));
      end
      m_req = '0;

      // Master 1 write stretched by five wait states.
      do_reset();
      m_req = 2'b10; m_we = 2'b10; m_addr = {16'h2222, 16'h0000}; m_wdata = {16'hCAFE, 16'h0000};
      s_wait = 1'b1;
      cnt_en = 0; cnt_done = 0; cnt_err = 0; addr_bad = 0; done_val = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (s_en) begin
            cnt_en++;
            if (s_addr !== 16'h2222 || s_wdata !== 16'hCAFE) addr_bad++;
         end
         if (m_done != 0) begin cnt_done++; done_val = m_done; end
         if (m_err != 0) cnt_err++;
         if (c == 1) m_req = '0;
         if (c == 6) s_wait = 1'b0;
      end
      chk("wait s_en cycles", 32'(cnt_en), 32'd6);
      chk("wait addr stable", 32'(addr_bad), 32'd0);
      chk("wait done count",  32'(cnt_done), 32'd1);
      chk("wait done master", 32'(done_val), 32'b10);
      chk("wait err count",   32'(cnt_err), 32'd0);

      // Timeout on the TIMEOUT=4 instance after a preload read.
      do_reset();
      pre = vecs[0];
      pre.rd = 16'h1357;
      run_vec(pre, "preload");
      chk("to preload rdata", 32'(to_rdata), 32'h1357);
      m_req = 2'b01; m_addr = {16'h0000, 16'h0321}; s_wait = 1'b1; s_rdata = 16'hDEAD;
      cnt_done = 0; cnt_err = 0; err_cyc = 0; err_val = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (to_err != 0) begin cnt_err++; err_cyc = c; err_val = to_err; end
         if (to_done != 0) cnt_done++;
         if (c == 1) m_req = '0;
      end
      chk("to err cycle",  32'(err_cyc), 32'd6);
      chk("to err count",  32'(cnt_err), 32'd1);
      chk("to err master", 32'(err_val), 32'b01);
      chk("to no done",    32'(cnt_done), 32'd0);
      chk("to rdata kept", 32'(to_rdata), 32'h1357);
      chk("to back idle",  32'({to_s_en, to_gnt}), 32'd0);
      s_wait = 1'b0;

      // Reset in the middle of a stalled write.
      do_reset();
      pre = vecs[3];
      pre.rd = 16'h7777;
      run_vec(pre, "rstpre");
      m_req = 2'b01; m_we = 2'b01; m_byte_en = 2'b01; m_addr = {16'h0000, 16'h3C3C};
      m_wdata = {16'h0000, 16'h5A5A}; s_wait = 1'b1;
      pulses = 0;
      @(negedge clk);
      chk("rst_mid busy", 32'({s_en, s_we, s_byte_en}), 32'b111);
      m_req = '0;
      pulses += (m_done != 0 || m_err != 0) ? 1 : 0;
      @(negedge clk);
      pulses += (m_done != 0 || m_err != 0) ? 1 : 0;
      rst_n = 1'b0;
      @(negedge clk);
      pulses += (m_done != 0 || m_err != 0) ? 1 : 0;
      chk("rst_mid ctrl",  32'({m_gnt, m_done, m_err, s_en, s_we, s_byte_en}), 32'd0);
      chk("rst_mid data",  32'({s_addr, s_wdata}), 32'd0);
      chk("rst_mid rdata", 32'(m_rdata), 32'd0);
      rst_n = 1'b1; s_wait = 1'b0; clear_inputs();
      m_req = 2'b10; m_addr = {16'h0042, 16'h0000}; s_rdata = 16'h0BAD;
      @(negedge clk);
      chk("rst_mid regrant", 32'(m_gnt), 32'b10);
      chk("rst_mid readdr",  32'(s_addr), 32'h0042);
      m_req = '0;
      @(negedge clk);
      chk("rst_mid redone",  32'(m_done), 32'b10);
      chk("rst_mid pulses",  32'(pulses), 32'd0);
      @(negedge clk);

      // Master 0 drops its request and moves its address mid-access.
      do_reset();
      m_req = 2'b01; m_addr = {16'h0000, 16'h0456}; s_wait = 1'b1; s_rdata = 16'h6060;
      cnt_done = 0; addr_bad = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (s_en && s_addr !== 16'h0456) addr_bad++;
         if (m_done != 0) begin cnt_done++; done_val = m_done; end
         if (c == 1) begin m_req = '0; m_addr = {16'h0000, 16'h0999}; end
         if (c == 2) s_wait = 1'b0;
      end
      chk("drop addr held",  32'(addr_bad), 32'd0);
      chk("drop done count", 32'(cnt_done), 32'd1);
      chk("drop done mast",  32'(done_val), 32'b01);
      chk("drop rdata",      32'(m_rdata), 32'h6060);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
